axi_2_mem_core: RTL and testbench

AXI_2_MEM_CORE -- requirements
Module: axi_2_mem_core

---
 rtl/axi_2_mem_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_2_mem_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_2_mem_core.sv
// AXI4 subordinate to single-port SRAM bridge.
// One single-beat transaction at a time; bursts are drained with SLVERR.
package axi_2_mem_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

module axi_2_mem_core
  import axi_2_mem_pkg::*;
#(
  parameter int  MEM_ADDRW  = 32,
  parameter int  MEM_DATAW  = 32,
  parameter int  MEM_STRBW  = MEM_DATAW / 8,
  parameter type axi_req_t  = axi_2_mem_pkg::axi_req_t,
  parameter type axi_resp_t = axi_2_mem_pkg::axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  axi_req_t             axi_req_i,
  output axi_resp_t            axi_resp_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [MEM_ADDRW-1:0] mem_addr_o,
  output logic [MEM_DATAW-1:0] mem_wdata_o,
  output logic [MEM_STRBW-1:0] mem_be_o,
  input  logic [MEM_DATAW-1:0] mem_rdata_i
);

  localparam int OFFW = $clog2(MEM_STRBW);
  localparam int IDW  = $bits(axi_req_i.ar.id);

  typedef enum logic [3:0] {
    IDLE, RD_MEM, RD_CAP, RD_RESP, WR_DATA,
    WR_MEM, WR_RESP, RD_ERR, WR_DRAIN, WR_ERR
  } state_e;

  state_e               state_q, state_d;
  logic                 prio_q, prio_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           len_q;
  logic [MEM_ADDRW-1:0] addr_q;
  logic [IDW-1:0]       id_q;
  logic [MEM_DATAW-1:0] wdata_q, rdata_q;
  logic [MEM_STRBW-1:0] strb_q;
  logic                 ld_ar, ld_aw, ld_w;
  logic                 grant_r, grant_w, contend;
  logic                 err_last;
  logic                 unused_ok;

  assign unused_ok = ^{axi_req_i.ar.size, axi_req_i.ar.burst,
                       axi_req_i.aw.size, axi_req_i.aw.burst,
                       axi_req_i.aw.atop};

  // prio_q=1 favours write; it only flips when both channels contend
  assign contend  = axi_req_i.ar_valid & axi_req_i.aw_valid;
  assign grant_w  = axi_req_i.aw_valid & (~axi_req_i.ar_valid | prio_q);
  assign grant_r  = axi_req_i.ar_valid & (~axi_req_i.aw_valid | ~prio_q);
  assign err_last = (cnt_q == len_q);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b1;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      if (ld_ar) begin
        addr_q <= axi_req_i.ar.addr;
        id_q   <= axi_req_i.ar.id;
        len_q  <= axi_req_i.ar.len;
      end
      if (ld_aw) begin
        addr_q <= axi_req_i.aw.addr;
        id_q   <= axi_req_i.aw.id;
        len_q  <= axi_req_i.aw.len;
      end
      if (ld_w) begin
        wdata_q <= axi_req_i.w.data;
        strb_q  <= axi_req_i.w.strb;
      end
      if (state_q == RD_CAP) rdata_q <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    ld_ar       = 1'b0;
    ld_aw       = 1'b0;
    ld_w        = 1'b0;
    axi_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    // outputs stay quiet while reset is held, even with valids pending
    if (arst_ni) begin
      unique case (state_q)
        IDLE: begin
          if (contend) prio_d = ~prio_q;
          unique case (1'b1)
            grant_w: begin
              axi_resp_o.aw_ready = 1'b1;
              ld_aw   = 1'b1;
              state_d = (axi_req_i.aw.len != 8'd0) ? WR_DRAIN : WR_DATA;
            end
            grant_r: begin
              axi_resp_o.ar_ready = 1'b1;
              ld_ar   = 1'b1;
              cnt_d   = '0;
              state_d = (axi_req_i.ar.len != 8'd0) ? RD_ERR : RD_MEM;
            end
            default: ;
          endcase
        end
        RD_MEM: begin
          mem_req_o  = 1'b1;
          mem_addr_o = (addr_q >> OFFW) << OFFW;
          state_d    = RD_CAP;
        end
        RD_CAP: state_d = RD_RESP;
        RD_RESP: begin
          axi_resp_o.r_valid = 1'b1;
          axi_resp_o.r.data  = rdata_q;
          axi_resp_o.r.resp  = RESP_OKAY;
          axi_resp_o.r.last  = 1'b1;
          axi_resp_o.r.id    = id_q;
          if (axi_req_i.r_ready) state_d = IDLE;
        end
        WR_DATA: begin
          axi_resp_o.w_ready = 1'b1;
          if (axi_req_i.w_valid) begin
            ld_w    = 1'b1;
            state_d = WR_MEM;
          end
        end
        WR_MEM: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = (addr_q >> OFFW) << OFFW;
          mem_wdata_o = wdata_q;
          mem_be_o    = strb_q;
          state_d     = WR_RESP;
        end
        WR_RESP: begin
          axi_resp_o.b_valid = 1'b1;
          axi_resp_o.b.resp  = RESP_OKAY;
          axi_resp_o.b.id    = id_q;
          if (axi_req_i.b_ready) state_d = IDLE;
        end
        RD_ERR: begin
          axi_resp_o.r_valid = 1'b1;
          axi_resp_o.r.resp  = RESP_SLVERR;
          axi_resp_o.r.last  = err_last;
          axi_resp_o.r.id    = id_q;
          if (axi_req_i.r_ready) begin
            if (err_last) state_d = IDLE;
            else          cnt_d   = cnt_q + 8'd1;
          end
        end
        WR_DRAIN: begin
          axi_resp_o.w_ready = 1'b1;
          if (axi_req_i.w_valid && axi_req_i.w.last) state_d = WR_ERR;
        end
        WR_ERR: begin
          axi_resp_o.b_valid = 1'b1;
          axi_resp_o.b.resp  = RESP_SLVERR;
          axi_resp_o.b.id    = id_q;
          if (axi_req_i.b_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_2_mem_core.sv
// Directed bench for axi_2_mem_core with a one-cycle-latency SRAM model.
// Inputs change on the falling edge; outputs are checked before the rising edge.
module tb_axi_2_mem_core;
  import axi_2_mem_pkg::*;

  logic        clk;
  logic        arst_ni;
  axi_req_t    req;
  axi_resp_t   resp;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] mem [256];
  int          tests, fails, nreq;

  axi_2_mem_core dut (
    .clk_i      (clk),
    .arst_ni    (arst_ni),
    .axi_req_i  (req),
    .axi_resp_o (resp),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o   (mem_be),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) begin
      nreq++;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic test_reset();
    arst_ni = 1'b0;
    req = '0;
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (resp !== '0) begin fails++; $display("FAIL rst_resp: got %h want 0", resp); end
    tests++; if ({mem_req, mem_we, mem_be} !== '0) begin fails++; $display("FAIL rst_mem: got %b%b%h want 0", mem_req, mem_we, mem_be); end
    tests++; if ({mem_addr, mem_wdata} !== '0) begin fails++; $display("FAIL rst_bus: got %h %h want 0", mem_addr, mem_wdata); end
    req = '0;
    arst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    nreq = 0;
    req.ar_valid = 1'b1;
    req.ar.addr = 32'hAB;
    req.ar.id = 4'd3;
    req.ar.len = 8'd0;
    #1;
    tests++; if (resp.ar_ready !== 1'b1) begin fails++; $display("FAIL rd_arready: got %b want 1", resp.ar_ready); end
    @(negedge clk);
    req.ar_valid = 1'b0;
    tests++; if ({mem_req, mem_we} !== 2'b10) begin fails++; $display("FAIL rd_memreq: got %b want 10", {mem_req, mem_we}); end
    tests++; if (mem_addr !== 32'hA8) begin fails++; $display("FAIL rd_addr: got %h want a8", mem_addr); end
    tests++; if (resp.ar_ready !== 1'b0) begin fails++; $display("FAIL rd_arbusy: got %b want 0", resp.ar_ready); end
    @(negedge clk);
    tests++; if ({mem_req, resp.r_valid} !== 2'b00) begin fails++; $display("FAIL rd_cap: got %b want 00", {mem_req, resp.r_valid}); end
    @(negedge clk);
    tests++; if (resp.r_valid !== 1'b1) begin fails++; $display("FAIL rd_lat3: got %b want 1", resp.r_valid); end
    tests++; if (resp.r !== {4'd3, 32'h45, RESP_OKAY, 1'b1}) begin fails++; $display("FAIL rd_beat: got %h want 3/45/0/1", resp.r); end
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    tests++; if (resp.r_valid !== 1'b0) begin fails++; $display("FAIL rd_done: got %b want 0", resp.r_valid); end
    tests++; if (nreq !== 1) begin fails++; $display("FAIL rd_nreq: got %0d want 1", nreq); end
  endtask

  task automatic test_write();
    req.aw_valid = 1'b1;
    req.aw.addr = 32'hAB;
    req.aw.id = 4'd5;
    req.aw.len = 8'd0;
    #1;
    tests++; if ({resp.aw_ready, resp.w_ready} !== 2'b10) begin fails++; $display("FAIL wr_awready: got %b want 10", {resp.aw_ready, resp.w_ready}); end
    @(negedge clk);
    req.aw_valid = 1'b0;
    tests++; if (resp.w_ready !== 1'b1) begin fails++; $display("FAIL wr_wready: got %b want 1", resp.w_ready); end
    @(negedge clk);
    req.w_valid = 1'b1;
    req.w = {32'h69, 4'hF, 1'b1};
    @(negedge clk);
    req.w_valid = 1'b0;
    tests++; if ({mem_req, mem_we, mem_be} !== 6'b11_1111) begin fails++; $display("FAIL wr_mem: got %b want 111111", {mem_req, mem_we, mem_be}); end
    tests++; if ({mem_addr, mem_wdata} !== {32'hA8, 32'h69}) begin fails++; $display("FAIL wr_bus: got %h %h want a8 69", mem_addr, mem_wdata); end
    tests++; if (resp.w_ready !== 1'b0) begin fails++; $display("FAIL wr_wbusy: got %b want 0", resp.w_ready); end
    @(negedge clk);
    tests++; if ({resp.b_valid, resp.b} !== {1'b1, 4'd5, RESP_OKAY}) begin fails++; $display("FAIL wr_b: got %b %h want 1 14", resp.b_valid, resp.b); end
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    tests++; if (resp.b_valid !== 1'b0) begin fails++; $display("FAIL wr_bdone: got %b want 0", resp.b_valid); end
    tests++; if (mem[8'h2A] !== 32'h69) begin fails++; $display("FAIL wr_memval: got %h want 69", mem[8'h2A]); end
  endtask

  task automatic test_strb_zero();
    req.w_valid = 1'b1;
    req.w = {32'hDEAD_BEEF, 4'h0, 1'b1};
    #1;
    tests++; if (resp.w_ready !== 1'b0) begin fails++; $display("FAIL w_early: got %b want 0", resp.w_ready); end
    @(negedge clk);
    tests++; if (resp.w_ready !== 1'b0) begin fails++; $display("FAIL w_stall: got %b want 0", resp.w_ready); end
    req.aw_valid = 1'b1;
    req.aw.addr = 32'h10;
    req.aw.id = 4'd1;
    @(negedge clk);
    req.aw_valid = 1'b0;
    tests++; if (resp.w_ready !== 1'b1) begin fails++; $display("FAIL s0_wready: got %b want 1", resp.w_ready); end
    @(negedge clk);
    req.w_valid = 1'b0;
    tests++; if ({mem_req, mem_we, mem_be} !== 6'b11_0000) begin fails++; $display("FAIL s0_mem: got %b want 110000", {mem_req, mem_we, mem_be}); end
    @(negedge clk);
    tests++; if ({resp.b_valid, resp.b} !== {1'b1, 4'd1, RESP_OKAY}) begin fails++; $display("FAIL s0_b: got %b %h want 1 04", resp.b_valid, resp.b); end
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    tests++; if (mem[4] !== 32'h1234_5678) begin fails++; $display("FAIL s0_memval: got %h want 12345678", mem[4]); end
  endtask

  task automatic test_prio();
    req.ar_valid = 1'b1;
    req.ar.addr = 32'h10;
    req.ar.id = 4'd7;
    req.ar.len = 8'd0;
    req.aw_valid = 1'b1;
    req.aw.addr = 32'h20;
    req.aw.id = 4'd2;
    req.aw.len = 8'd0;
    #1;
    tests++; if ({resp.aw_ready, resp.ar_ready} !== 2'b10) begin fails++; $display("FAIL pr1_grant: got %b want 10", {resp.aw_ready, resp.ar_ready}); end
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1;
    req.w = {32'h11, 4'hF, 1'b1};
    tests++; if (resp.ar_ready !== 1'b0) begin fails++; $display("FAIL pr1_arbusy: got %b want 0", resp.ar_ready); end
    @(negedge clk);
    req.w_valid = 1'b0;
    @(negedge clk);
    tests++; if (resp.b.id !== 4'd2) begin fails++; $display("FAIL pr1_bid: got %h want 2", resp.b.id); end
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    tests++; if (resp.ar_ready !== 1'b1) begin fails++; $display("FAIL pr1_rd: got %b want 1", resp.ar_ready); end
    @(negedge clk);
    req.ar_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({resp.r_valid, resp.r.id, resp.r.data} !== {1'b1, 4'd7, 32'h1234_5678}) begin fails++; $display("FAIL pr1_r: got %b %h %h want 1 7 12345678", resp.r_valid, resp.r.id, resp.r.data); end
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    req.ar_valid = 1'b1;
    req.ar.id = 4'd8;
    req.aw_valid = 1'b1;
    req.aw.id = 4'd9;
    #1;
    tests++; if ({resp.aw_ready, resp.ar_ready} !== 2'b01) begin fails++; $display("FAIL pr2_grant: got %b want 01", {resp.aw_ready, resp.ar_ready}); end
    @(negedge clk);
    req.ar_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({resp.r_valid, resp.r.id} !== {1'b1, 4'd8}) begin fails++; $display("FAIL pr2_r: got %b %h want 1 8", resp.r_valid, resp.r.id); end
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    tests++; if (resp.aw_ready !== 1'b1) begin fails++; $display("FAIL pr2_wr: got %b want 1", resp.aw_ready); end
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1;
    @(negedge clk);
    req.w_valid = 1'b0;
    @(negedge clk);
    tests++; if ({resp.b_valid, resp.b.id} !== {1'b1, 4'd9}) begin fails++; $display("FAIL pr2_b: got %b %h want 1 9", resp.b_valid, resp.b.id); end
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  task automatic test_err_read();
    nreq = 0;
    req.ar_valid = 1'b1;
    req.ar.addr = 32'h40;
    req.ar.id = 4'd4;
    req.ar.len = 8'd3;
    req.r_ready = 1'b1;
    #1;
    tests++; if (resp.ar_ready !== 1'b1) begin fails++; $display("FAIL er_arready: got %b want 1", resp.ar_ready); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      req.ar_valid = 1'b0;
      tests++;
      if ({resp.r_valid, resp.r} !== {1'b1, 4'd4, 32'h0, RESP_SLVERR, b == 3}) begin
        fails++; $display("FAIL er_beat%0d: got %b %h want 1 4/0/2/%0d", b, resp.r_valid, resp.r, b == 3);
      end
    end
    @(negedge clk);
    req.r_ready = 1'b0;
    tests++; if (resp.r_valid !== 1'b0) begin fails++; $display("FAIL er_done: got %b want 0", resp.r_valid); end
    tests++; if (nreq !== 0) begin fails++; $display("FAIL er_nreq: got %0d want 0", nreq); end
  endtask

  task automatic test_err_write();
    nreq = 0;
    req.aw_valid = 1'b1;
    req.aw.addr = 32'h30;
    req.aw.id = 4'd6;
    req.aw.len = 8'd1;
    #1;
    tests++; if (resp.aw_ready !== 1'b1) begin fails++; $display("FAIL ew_awready: got %b want 1", resp.aw_ready); end
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1;
    req.w = {32'hAA, 4'hF, 1'b0};
    #1;
    tests++; if (resp.w_ready !== 1'b1) begin fails++; $display("FAIL ew_w1: got %b want 1", resp.w_ready); end
    @(negedge clk);
    req.w = {32'hBB, 4'hF, 1'b1};
    #1;
    tests++; if ({resp.w_ready, resp.b_valid} !== 2'b10) begin fails++; $display("FAIL ew_w2: got %b want 10", {resp.w_ready, resp.b_valid}); end
    @(negedge clk);
    req.w_valid = 1'b0;
    tests++; if ({resp.b_valid, resp.b, resp.w_ready} !== {1'b1, 4'd6, RESP_SLVERR, 1'b0}) begin fails++; $display("FAIL ew_b: got %b %h %b want 1 1a 0", resp.b_valid, resp.b, resp.w_ready); end
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    tests++; if ({resp.b_valid, nreq[3:0]} !== 5'b0) begin fails++; $display("FAIL ew_done: got %b %0d want 0 0", resp.b_valid, nreq); end
  endtask

  task automatic test_stall_reset();
    req.ar_valid = 1'b1;
    req.ar.addr = 32'h10;
    req.ar.id = 4'd1;
    req.ar.len = 8'd0;
    @(negedge clk);
    req.ar_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({resp.r_valid, resp.r.data} !== {1'b1, 32'h1234_5678}) begin
        fails++; $display("FAIL st_hold%0d: got %b %h want 1 12345678", c, resp.r_valid, resp.r.data);
      end
      @(negedge clk);
    end
    arst_ni = 1'b0;
    #1;
    tests++; if (resp !== '0) begin fails++; $display("FAIL st_abort: got %h want 0", resp); end
    @(negedge clk);
    arst_ni = 1'b1;
    @(negedge clk);
    tests++; if (resp.r_valid !== 1'b0) begin fails++; $display("FAIL st_noresp: got %b want 0", resp.r_valid); end
    req.ar_valid = 1'b1;
    req.ar.id = 4'd2;
    #1;
    tests++; if (resp.ar_ready !== 1'b1) begin fails++; $display("FAIL st_newar: got %b want 1", resp.ar_ready); end
    @(negedge clk);
    req.ar_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({resp.r_valid, resp.r.id} !== {1'b1, 4'd2}) begin fails++; $display("FAIL st_newr: got %b %h want 1 2", resp.r_valid, resp.r.id); end
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nreq = 0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h2A] = 32'h45;
    mem[4] = 32'h1234_5678;
    test_reset();
    test_read();
    test_write();
    test_strb_zero();
    test_prio();
    test_err_read();
    test_err_write();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
